// File: rtl/shiftreg_param_ctl_if.sv
// rtl/shiftreg_param_ctl_if.sv - control/data bundle for the parametrised burst shift register
interface shiftreg_param_ctl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             sclr;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [1:0]       mode;
    logic             shift_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             shift_out;
    logic             busy;
    logic             done;

    modport master (
        output sclr, enable, load, data, dir, mode, shift_in, start, count,
        input  q, shift_out, busy, done
    );

    modport slave (
        input  sclr, enable, load, data, dir, mode, shift_in, start, count,
        output q, shift_out, busy, done
    );
endinterface

// File: rtl/shiftreg_param_ctl.sv
// rtl/shiftreg_param_ctl.sv - shift register with run-time direction/fill mode and Start/Busy/Done burst shifter
module shiftreg_param_ctl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                clk_i,
    input  logic                aclr_n_i,
    shiftreg_param_ctl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] rem_q;
    logic             bdir_q;
    logic [1:0]       bmode_q;
    logic             eff_dir;
    logic [1:0]       eff_mode;

    // A running burst uses the direction/mode captured at Start, never the live inputs.
    always_comb begin
        eff_dir  = (state_q == S_SHIFT) ? bdir_q  : bus.dir;
        eff_mode = (state_q == S_SHIFT) ? bmode_q : bus.mode;
        shift_d  = q_q;
        case (eff_mode)
            2'b01: shift_d = eff_dir ? {q_q[WIDTH-2:0], q_q[WIDTH-1]}
                                     : {q_q[0], q_q[WIDTH-1:1]};
            2'b10: shift_d = eff_dir ? {q_q[WIDTH-2:0], 1'b0}
                                     : {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default: shift_d = eff_dir ? {q_q[WIDTH-2:0], bus.shift_in}
                                       : {bus.shift_in, q_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            bdir_q  <= 1'b0;
            bmode_q <= 2'b00;
        end else if (bus.sclr) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
        end else if (bus.load) begin
            state_q <= S_IDLE;
            q_q     <= bus.data;
            rem_q   <= '0;
        end else if (bus.start && state_q != S_SHIFT) begin
            bdir_q  <= bus.dir;
            bmode_q <= bus.mode;
            rem_q   <= bus.count;
            state_q <= (bus.count == '0) ? S_DONE : S_SHIFT;
        end else if (state_q == S_SHIFT) begin
            if (bus.enable) begin
                q_q   <= shift_d;
                rem_q <= rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    state_q <= S_DONE;
                end
            end
        end else begin
            // IDLE or DONE: manual shift with live controls; DONE always falls back to IDLE.
            if (bus.enable) begin
                q_q <= shift_d;
            end
            state_q <= S_IDLE;
        end
    end

    assign bus.q         = q_q;
    assign bus.shift_out = eff_dir ? q_q[WIDTH-1] : q_q[0];
    assign bus.busy      = (state_q == S_SHIFT);
    assign bus.done      = (state_q == S_DONE);
endmodule
